shiftrows_pipe: RTL



---
 rtl/shiftrows_pipe_if.sv | 38 +++
 rtl/shiftrows_pipe.sv | 84 ++++++++
 2 files changed

// File: rtl/shiftrows_pipe_if.sv
// Handshake bundle for the ShiftRows pipeline: input beat (valid/ready/mode/state) and output beat.
// master is the surrounding datapath view, slave is the permutation unit view.
interface shiftrows_pipe_if #(
    parameter int NB = 4
);
    localparam int W = 32 * NB;

    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [W-1:0] ip;
    logic         out_valid;
    logic         out_ready;
    logic         out_mode;
    logic [W-1:0] op;

    modport master (
        output in_valid,
        output in_mode,
        output ip,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_mode,
        input  op
    );

    modport slave (
        input  in_valid,
        input  in_mode,
        input  ip,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_mode,
        output op
    );
endinterface

// File: rtl/shiftrows_pipe.sv
// Two-stage elastic Rijndael ShiftRows / InvShiftRows unit for NB 32-bit columns.
// Direction travels with each beat; column 0 and row 0 sit at the most significant end.
module shiftrows_pipe #(
    parameter int NB = 4
) (
    input  logic             clk,
    input  logic             rst,
    shiftrows_pipe_if.slave  bus
);
    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_illegalNb
        $fatal(1, "shiftrows_pipe: NB must be 4, 6 or 8");
    end

    // Rijndael row offsets: 0,1,2,3 for NB 4/6, and 0,1,3,4 for the 256-bit block.
    function automatic int shiftOf(input int r);
        if (NB == 8 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

    logic [W-1:0] r_s1Data;
    logic         r_s1Mode;
    logic         r_s1Valid;
    logic [W-1:0] r_s2Data;
    logic         r_s2Mode;
    logic         r_s2Valid;

    logic [W-1:0] w_perm;
    logic         w_s2Adv;
    logic         w_s1Adv;
    logic         w_inReady;
    logic         w_s1Load;

    // Pure byte routing: every output byte picks one of two source columns by mode.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int S    = shiftOf(r);
            localparam int SRCF = (c + S) % NB;
            localparam int SRCI = (c + NB - S) % NB;
            assign w_perm[W-1-32*c-8*r -: 8] = r_s1Mode ? r_s1Data[W-1-32*SRCI-8*r -: 8]
                                                        : r_s1Data[W-1-32*SRCF-8*r -: 8];
        end
    end

    assign w_s2Adv   = !r_s2Valid || bus.out_ready;
    assign w_s1Adv   = !r_s1Valid || w_s2Adv;
    assign w_inReady = w_s1Adv && !rst;
    assign w_s1Load  = bus.in_valid && w_inReady;

    // S1 refills in the same cycle its beat moves to S2, so a full pipe streams without bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Data  <= '0;
            r_s1Mode  <= 1'b0;
            r_s2Valid <= 1'b0;
            r_s2Data  <= '0;
            r_s2Mode  <= 1'b0;
        end else begin
            if (w_s1Adv) begin
                r_s1Valid <= w_s1Load;
                if (w_s1Load) begin
                    r_s1Data <= bus.ip;
                    r_s1Mode <= bus.in_mode;
                end
            end
            if (w_s2Adv) begin
                r_s2Valid <= r_s1Valid;
                if (r_s1Valid) begin
                    r_s2Data <= w_perm;
                    r_s2Mode <= r_s1Mode;
                end
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_s2Valid;
    assign bus.out_mode  = r_s2Mode;
    assign bus.op        = r_s2Data;
endmodule
